// File: rtl/memhex_scan.sv
// ---------------------------------------------------------------------------
// memhex_scan
// Periodically scans eight nibbles out of a shared 16x4 single-port RAM and
// presents them as a 32-bit display word. External writes to the same RAM
// always win the port; a scan simply stalls while a write is granted.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   wr_req    external write request (level, held until wr_ack)
//   wr_addr   write address
//   wr_data   write nibble
//   wr_ack    write granted this cycle
//   scan_now  one-cycle pulse forcing a scan when idle
//   ram_addr  RAM address
//   ram_din   RAM write data
//   ram_we    RAM write enable
//   ram_dout  RAM read data, valid one cycle after the address
//   digits    committed display nibbles, digit i at [4i+3:4i]
//   valid     set once the first full scan has committed
//   busy      high while a scan is in progress
// ---------------------------------------------------------------------------
module memhex_scan #(
  parameter int unsigned DIV  = 50000,
  parameter logic [3:0]  BASE = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_data,
  output logic        wr_ack,
  input  logic        scan_now,
  output logic [3:0]  ram_addr,
  output logic [3:0]  ram_din,
  output logic        ram_we,
  input  logic [3:0]  ram_dout,
  output logic [31:0] digits,
  output logic        valid,
  output logic        busy
);

  // Wide enough to hold DIV-1 for the largest legal DIV (2^20).
  localparam int unsigned TW = 21;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick;
  logic [3:0]    idx;
  logic          rd_pend;
  logic [2:0]    rd_idx;
  logic [31:0]   shadow;
  logic [31:0]   captured;
  logic          grant;
  logic          issue;
  logic          start;
  logic          commit;

  // The write port is granted combinationally; reset masks it so the RAM
  // sees no write while the block is held in reset.
  assign grant    = wr_req & ~reset;
  assign wr_ack   = grant;
  assign ram_we   = grant;
  assign ram_din  = grant ? wr_data : 4'h0;
  assign ram_addr = grant ? wr_addr : 4'(BASE + idx);
  assign busy     = (state == SCAN);

  // Shadow with the pending read merged in; used both to update the shadow
  // and, on the last capture, as the committed display word.
  always_comb begin
    captured = shadow;
    captured[{rd_idx, 2'b00} +: 4] = ram_dout;
  end

  // Next-state and scan control. A read is only issued when no write holds
  // the port; the final capture (idx 7) commits and ends the scan.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    start      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (tick == TICK_LAST || scan_now) begin
          state_next = SCAN;
          start      = 1'b1;
        end
      end
      SCAN: begin
        issue = ~wr_req & ~idx[3];
        if (rd_pend && rd_idx == 3'd7) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, tick counter and read sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      idx     <= 4'd0;
      rd_pend <= 1'b0;
      rd_idx  <= 3'd0;
    end else begin
      state   <= state_next;
      rd_pend <= issue;
      if (start) begin
        tick <= '0;
        idx  <= 4'd0;
      end else begin
        if (state == IDLE)
          tick <= tick + TW'(1);
        if (issue) begin
          idx    <= idx + 4'd1;
          rd_idx <= idx[2:0];
        end
      end
    end
  end

  // Shadow capture and atomic commit to the display word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= 32'h0;
      digits <= 32'h0;
      valid  <= 1'b0;
    end else begin
      if (rd_pend)
        shadow <= captured;
      if (commit) begin
        digits <= captured;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memhex_scan.sv
// ---------------------------------------------------------------------------
// tb_memhex_scan
// Directed bench for memhex_scan. Two instances: a main one (BASE=0, long
// DIV so only scan_now starts scans) and a wrap one (BASE=E, DIV=10) for
// address wrap-around and free-running scan period.
// ---------------------------------------------------------------------------
module tb_memhex_scan;

  logic        clk;
  logic        reset;
  logic        wr_req;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_data;
  logic        wr_ack;
  logic        scan_now;
  logic [3:0]  ram_addr;
  logic [3:0]  ram_din;
  logic        ram_we;
  logic [3:0]  ram_dout;
  logic [31:0] digits;
  logic        valid;
  logic        busy;

  logic        w_reset;
  logic        w_wr_req;
  logic [3:0]  w_wr_addr;
  logic [3:0]  w_wr_data;
  logic        w_wr_ack;
  logic        w_scan_now;
  logic [3:0]  w_ram_addr;
  logic [3:0]  w_ram_din;
  logic        w_ram_we;
  logic [3:0]  w_ram_dout;
  logic [31:0] w_digits;
  logic        w_valid;
  logic        w_busy;

  logic [3:0] mem   [16];
  logic [3:0] w_mem [16];

  int n_checks;
  int n_fail;

  memhex_scan #(.DIV(1000), .BASE(4'h0)) u_main (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .scan_now(scan_now),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .digits(digits), .valid(valid), .busy(busy)
  );

  memhex_scan #(.DIV(10), .BASE(4'hE)) u_wrap (
    .clk(clk), .reset(w_reset), .wr_req(w_wr_req), .wr_addr(w_wr_addr),
    .wr_data(w_wr_data), .wr_ack(w_wr_ack), .scan_now(w_scan_now),
    .ram_addr(w_ram_addr), .ram_din(w_ram_din), .ram_we(w_ram_we),
    .ram_dout(w_ram_dout), .digits(w_digits), .valid(w_valid), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read single-port RAM models.
  always @(posedge clk) begin
    if (ram_we)
      mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(posedge clk) begin
    if (w_ram_we)
      w_mem[w_ram_addr] <= w_ram_din;
    w_ram_dout <= w_mem[w_ram_addr];
  end

  // Pulses scan_now on the main instance and counts busy cycles (bounded).
  task automatic run_scan(output int n);
    int guard;
    @(negedge clk);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    n = 0;
    guard = 0;
    while (busy && guard < 60) begin
      n++;
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    w_reset = 1'b1;
    wr_req = 1'b1;
    wr_addr = 4'h3;
    wr_data = 4'h5;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (digits !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state digits=%h valid=%b busy=%b expected 00000000/0/0", digits, valid, busy);
    end
    n_checks++;
    if (wr_ack !== 1'b0 || ram_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_write_mask wr_ack=%b ram_we=%b expected 0/0", wr_ack, ram_we);
    end
    wr_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    w_reset = 1'b0;
  endtask

  task automatic test_preload;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_req = 1'b1;
      wr_addr = 4'(i);
      wr_data = 4'(i);
      #1;
      n_checks++;
      if (wr_ack !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 4'(i) || ram_din !== 4'(i)) begin
        n_fail++;
        $display("[TB] FAIL preload_write%0d ack=%b we=%b addr=%h din=%h expected 1/1/%h/%h", i, wr_ack, ram_we, ram_addr, ram_din, 4'(i), 4'(i));
      end
    end
    @(negedge clk);
    wr_req = 1'b0;
    #1;
    n_checks++;
    if (wr_ack !== 1'b0 || ram_we !== 1'b0 || ram_din !== 4'h0 || ram_addr !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL idle_port ack=%b we=%b din=%h addr=%h expected 0/0/0/0", wr_ack, ram_we, ram_din, ram_addr);
    end
  endtask

  task automatic test_basic_scan;
    int n;
    run_scan(n);
    n_checks++;
    if (n != 9) begin
      n_fail++;
      $display("[TB] FAIL basic_busy_len got %0d expected 9", n);
    end
    n_checks++;
    if (digits !== 32'h76543210 || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_digits got %h valid=%b expected 76543210 valid=1", digits, valid);
    end
  endtask

  // Writes held for three cycles starting at idx 4, plus an ignored scan_now.
  task automatic test_back_to_back;
    int busy_cnt;
    int ack_cnt;
    int cyc;
    logic partial;
    @(negedge clk);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    busy_cnt = 0;
    ack_cnt = 0;
    partial = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      wr_req = 1'b0;
      scan_now = 1'b0;
      if (cyc == 2) scan_now = 1'b1;
      if (cyc == 4) begin wr_req = 1'b1; wr_addr = 4'h4; wr_data = 4'hB; end
      if (cyc == 5) begin wr_req = 1'b1; wr_addr = 4'h5; wr_data = 4'hC; end
      if (cyc == 6) begin wr_req = 1'b1; wr_addr = 4'h6; wr_data = 4'hD; end
      #1;
      if (!busy) break;
      busy_cnt++;
      if (wr_ack) ack_cnt++;
      if (digits !== 32'h76543210) partial = 1'b1;
      @(negedge clk);
    end
    wr_req = 1'b0;
    scan_now = 1'b0;
    n_checks++;
    if (busy_cnt != 12) begin
      n_fail++;
      $display("[TB] FAIL b2b_busy_len got %0d expected 12", busy_cnt);
    end
    n_checks++;
    if (ack_cnt != 3) begin
      n_fail++;
      $display("[TB] FAIL b2b_ack_count got %0d expected 3", ack_cnt);
    end
    n_checks++;
    if (partial !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_no_partial digits changed during scan");
    end
    n_checks++;
    if (digits !== 32'h7DCB3210) begin
      n_fail++;
      $display("[TB] FAIL b2b_digits got %h expected 7dcb3210", digits);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL no_queued_rescan busy=%b expected 0", busy);
    end
  endtask

  // Address 2 written after it was read: old value now, new value next scan.
  task automatic test_write_after_read;
    int busy_cnt;
    int n;
    @(negedge clk);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    busy_cnt = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      wr_req = 1'b0;
      if (cyc == 4) begin wr_req = 1'b1; wr_addr = 4'h2; wr_data = 4'hA; end
      #1;
      if (!busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    wr_req = 1'b0;
    n_checks++;
    if (busy_cnt != 10) begin
      n_fail++;
      $display("[TB] FAIL war_busy_len got %0d expected 10", busy_cnt);
    end
    n_checks++;
    if (digits !== 32'h7DCB3210) begin
      n_fail++;
      $display("[TB] FAIL war_old_digit got %h expected 7dcb3210", digits);
    end
    run_scan(n);
    n_checks++;
    if (n != 9 || digits !== 32'h7DCB3A10) begin
      n_fail++;
      $display("[TB] FAIL war_next_scan len=%0d digits=%h expected 9 7dcb3a10", n, digits);
    end
  endtask

  task automatic test_reset_mid_scan;
    int n;
    @(negedge clk);
    scan_now = 1'b1;
    @(negedge clk);
    scan_now = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (digits !== 32'h0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset digits=%h valid=%b busy=%b expected 00000000/0/0", digits, valid, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (digits !== 32'h0 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_no_commit digits=%h valid=%b expected 00000000/0", digits, valid);
    end
    run_scan(n);
    n_checks++;
    if (n != 9 || digits !== 32'h7DCB3A10 || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL after_reset_scan len=%0d digits=%h valid=%b expected 9 7dcb3a10 1", n, digits, valid);
    end
  endtask

  // BASE=E wrap-around and the free-running DIV=10 scan period.
  task automatic test_wrap_period;
    logic [3:0] addrs [8];
    int guard;
    int cyc;
    int busy_len;
    int changes;
    logic seen_low;
    logic [31:0] held;
    addrs = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_wr_req = 1'b1;
      w_wr_addr = addrs[i];
      w_wr_data = addrs[i];
    end
    @(negedge clk);
    w_wr_req = 1'b0;
    guard = 0;
    while (w_busy && guard < 60) begin guard++; @(negedge clk); end
    guard = 0;
    while (!w_busy && guard < 60) begin guard++; @(negedge clk); end
    n_checks++;
    if (!w_busy) begin
      n_fail++;
      $display("[TB] FAIL wrap_scan_start timeout busy=%b expected 1", w_busy);
    end
    cyc = 0;
    busy_len = 1;
    seen_low = 1'b0;
    changes = 0;
    held = 32'h0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      cyc++;
      if (!w_busy) begin
        if (!seen_low) held = w_digits;
        seen_low = 1'b1;
        if (w_digits !== held) changes++;
      end else if (seen_low) begin
        break;
      end else begin
        busy_len++;
      end
    end
    n_checks++;
    if (held !== 32'h543210FE || w_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_digits got %h valid=%b expected 543210fe 1", held, w_valid);
    end
    n_checks++;
    if (busy_len != 9) begin
      n_fail++;
      $display("[TB] FAIL wrap_busy_len got %0d expected 9", busy_len);
    end
    n_checks++;
    if (cyc != 19) begin
      n_fail++;
      $display("[TB] FAIL wrap_period got %0d expected 19", cyc);
    end
    n_checks++;
    if (changes != 0) begin
      n_fail++;
      $display("[TB] FAIL wrap_stable got %0d changes expected 0", changes);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    scan_now = 1'b0;
    wr_req = 1'b0;
    wr_addr = 4'h0;
    wr_data = 4'h0;
    w_scan_now = 1'b0;
    w_wr_req = 1'b0;
    w_wr_addr = 4'h0;
    w_wr_data = 4'h0;
    test_reset;
    test_preload;
    test_basic_scan;
    test_back_to_back;
    test_write_after_read;
    test_reset_mid_scan;
    test_wrap_period;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
